// File: rtl/uart_bus_responder.sv
// CPU-side UART responder: wrn-strobed transmit holding register feeding a serialiser,
// and a deserialiser feeding an rdn-read receive buffer. Optional feature: UART_LOOPBACK_EN.
module uart_bus_responder #(
  parameter int unsigned CLKS_PER_BIT = 96
) (
  input  logic       CLK,
  input  logic       RST,
`ifdef UART_LOOPBACK_EN
  input  logic       loopback,
`endif
  input  logic       wrn,
  input  logic       rdn,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       data_ready,
  output logic       tbre,
  output logic       tsre,
  output logic       txd,
  input  logic       rxd,
  output logic       framing_err,
  output logic       overrun
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  // Transmit state
  tx_state_e       tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic [7:0]      thr_q, thr_d;
  logic            thr_full_q, thr_full_d;
  logic            txd_q, txd_d;
  logic            tsre_q, tsre_d;
  logic            wrn_q;

  // Receive state
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_hold_q, rx_hold_d;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [7:0]      rbr_q, rbr_d;
  logic            data_ready_q, data_ready_d;
  logic            framing_err_q, framing_err_d;
  logic            overrun_q, overrun_d;
  logic            rdn_q;

  logic rx_in;
  logic wr_rise, rd_rise, load_shift, rx_done;

`ifdef UART_LOOPBACK_EN
  assign rx_in = loopback ? txd_q : rx_sync_q;
  assign txd   = loopback ? 1'b1 : txd_q;
`else
  assign rx_in = rx_sync_q;
  assign txd   = txd_q;
`endif

  assign wr_rise     = wrn & ~wrn_q;
  assign rd_rise     = rdn & ~rdn_q;
  assign tbre        = ~thr_full_q;
  assign tsre        = tsre_q;
  assign data_ready  = data_ready_q;
  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;
  assign data_oe     = ~rdn;
  assign data_out    = data_oe ? rbr_q : 8'h00;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    thr_d      = thr_q;
    thr_full_d = thr_full_q;
    txd_d      = txd_q;
    tsre_d     = tsre_q;
    load_shift = 1'b0;
    unique case (tx_state_q)
      TxIdle: load_shift = thr_full_q;
      TxStart: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          txd_d      = tx_shift_q[0];
          tx_state_d = TxData;
        end else begin
          tx_cnt_d = tx_cnt_q + CntW'(1);
        end
      end
      TxData: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TxStop;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CntW'(1);
        end
      end
      TxStop: begin
        if (tx_cnt_q == CntLast) begin
          // A pending THR byte starts at once, so consecutive frames have no idle gap.
          if (thr_full_q) begin
            load_shift = 1'b1;
          end else begin
            tx_state_d = TxIdle;
            tsre_d     = 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CntW'(1);
        end
      end
      default: tx_state_d = TxIdle;
    endcase
    if (load_shift) begin
      tx_shift_d = thr_q;
      thr_full_d = 1'b0;
      tsre_d     = 1'b0;
      txd_d      = 1'b0;
      tx_cnt_d   = '0;
      tx_state_d = TxStart;
    end
    if (wr_rise && !thr_full_q) begin
      thr_d      = data_in;
      thr_full_d = 1'b1;
    end
  end

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_hold_d     = rx_hold_q;
    rbr_d         = rbr_q;
    data_ready_d  = data_ready_q;
    framing_err_d = 1'b0;
    overrun_d     = 1'b0;
    rx_done       = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_in) begin
          rx_cnt_d   = '0;
          rx_state_d = RxStart;
        end
      end
      RxStart: begin
        if (rx_cnt_q == CntHalf) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_in ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + CntW'(1);
        end
      end
      RxData: begin
        if (rx_cnt_q == CntLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_in, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CntW'(1);
        end
      end
      RxStop: begin
        // After a bad stop bit, park here until the line returns high.
        if (rx_hold_q) begin
          if (rx_in) begin
            rx_hold_d  = 1'b0;
            rx_state_d = RxIdle;
          end
        end else if (rx_cnt_q == CntLast) begin
          rx_cnt_d = '0;
          if (rx_in) begin
            rx_done    = 1'b1;
            rx_state_d = RxIdle;
          end else begin
            framing_err_d = 1'b1;
            rx_hold_d     = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CntW'(1);
        end
      end
      default: rx_state_d = RxIdle;
    endcase
    // A byte landing on the read edge wins and is not counted as an overrun.
    if (rx_done) begin
      rbr_d        = rx_shift_q;
      data_ready_d = 1'b1;
      overrun_d    = data_ready_q & ~rd_rise;
    end else if (rd_rise) begin
      data_ready_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_state_q    <= TxIdle;
      tx_cnt_q      <= '0;
      tx_bit_q      <= 3'd0;
      tx_shift_q    <= 8'h00;
      thr_q         <= 8'h00;
      thr_full_q    <= 1'b0;
      txd_q         <= 1'b1;
      tsre_q        <= 1'b1;
      wrn_q         <= 1'b1;
      rx_state_q    <= RxIdle;
      rx_cnt_q      <= '0;
      rx_bit_q      <= 3'd0;
      rx_shift_q    <= 8'h00;
      rx_hold_q     <= 1'b0;
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      rx_prev_q     <= 1'b1;
      rbr_q         <= 8'h00;
      data_ready_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
      rdn_q         <= 1'b1;
    end else begin
      tx_state_q    <= tx_state_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_bit_q      <= tx_bit_d;
      tx_shift_q    <= tx_shift_d;
      thr_q         <= thr_d;
      thr_full_q    <= thr_full_d;
      txd_q         <= txd_d;
      tsre_q        <= tsre_d;
      wrn_q         <= wrn;
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      rx_hold_q     <= rx_hold_d;
      rx_meta_q     <= rxd;
      rx_sync_q     <= rx_meta_q;
      rx_prev_q     <= rx_in;
      rbr_q         <= rbr_d;
      data_ready_q  <= data_ready_d;
      framing_err_q <= framing_err_d;
      overrun_q     <= overrun_d;
      rdn_q         <= rdn;
    end
  end

endmodule

// File: tb/tb_uart_bus_responder.sv
// Bench for uart_bus_responder: queue-based transmit line model checked every cycle,
// plus directed receive/read vectors with hand-computed expectations.
module tb_uart_bus_responder;

  localparam int unsigned CPB = 4;

  logic       CLK = 1'b0;
  logic       RST, wrn, rdn, rxd;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe, data_ready, tbre, tsre, txd, framing_err, overrun;
`ifdef UART_LOOPBACK_EN
  logic       loopback = 1'b0;
`endif

  uart_bus_responder #(.CLKS_PER_BIT(CPB)) dut (
    .CLK        (CLK),
    .RST        (RST),
`ifdef UART_LOOPBACK_EN
    .loopback   (loopback),
`endif
    .wrn        (wrn),
    .rdn        (rdn),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_oe    (data_oe),
    .data_ready (data_ready),
    .tbre       (tbre),
    .tsre       (tsre),
    .txd        (txd),
    .rxd        (rxd),
    .framing_err(framing_err),
    .overrun    (overrun)
  );

  always #5 CLK = ~CLK;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line model: one expected txd value per upcoming cycle; empty queue means idle line.
  bit         exp_q[$];
  logic       m_thr_full = 1'b0;
  logic [7:0] m_thr = 8'h00;
  logic       m_wrn_prev = 1'b1;
  logic [7:0] m_rbr = 8'h00;
  int         fe_seen = 0;
  int         ov_seen = 0;

  function automatic void push_frame(input logic [7:0] b);
    for (int i = 0; i < 10; i++) begin
      bit v;
      v = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
      for (int c = 0; c < int'(CPB); c++) exp_q.push_back(v);
    end
  endfunction

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      exp_q.delete();
      m_thr_full = 1'b0;
      m_wrn_prev = 1'b1;
    end else begin
      logic was_full;
      was_full = m_thr_full;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (exp_q.size() == 0 && was_full) begin
        push_frame(m_thr);
        m_thr_full = 1'b0;
      end
      if (wrn && !m_wrn_prev && !was_full) begin
        m_thr      = data_in;
        m_thr_full = 1'b1;
      end
      m_wrn_prev = wrn;
    end
  end

  always @(negedge CLK) begin
    logic exp_txd;
    exp_txd = (exp_q.size() > 0) ? exp_q[0] : 1'b1;
`ifdef UART_LOOPBACK_EN
    if (loopback) exp_txd = 1'b1;
`endif
    chk("txd", txd, exp_txd);
    chk("tsre", tsre, exp_q.size() == 0);
    chk("tbre", tbre, !m_thr_full);
    chk("data_oe", data_oe, !rdn);
    if (!rdn) chk("data_out", data_out, m_rbr);
    if (framing_err) fe_seen++;
    if (overrun) ov_seen++;
  end

  task automatic wr(input logic [7:0] b);
    @(posedge CLK); #1 wrn = 1'b0; data_in = b;
    @(posedge CLK); #1 wrn = 1'b1;
  endtask

  task automatic rd(input logic [7:0] b);
    @(posedge CLK); #1 rdn = 1'b0;
    @(negedge CLK);
    chk("rd_oe", data_oe, 1);
    chk("rd_data", data_out, b);
    @(posedge CLK); #1 rdn = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("rd_ready_clr", data_ready, 0);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    @(posedge CLK); #1;
    for (int i = 0; i < 10; i++) begin
      rxd = (i == 0) ? 1'b0 : (i == 9) ? stop_bit : b[i-1];
      repeat (CPB) @(posedge CLK);
      #1;
    end
    rxd = 1'b1;
    repeat (2 * CPB) @(posedge CLK);
    #1;
    if (stop_bit) m_rbr = b;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_txd"}, txd, 1);
    chk({tag, "_tbre"}, tbre, 1);
    chk({tag, "_tsre"}, tsre, 1);
    chk({tag, "_ready"}, data_ready, 0);
    chk({tag, "_dout"}, data_out, 0);
    chk({tag, "_oe"}, data_oe, 0);
    chk({tag, "_ferr"}, framing_err, 0);
    chk({tag, "_ovr"}, overrun, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run still active at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    logic [9:0]  cap_a5;
    logic [9:0]  exp_a5;
    logic [21:0] cap_b2b;
    logic [21:0] exp_b2b;
    int ones, fe0, ov0;
    exp_a5  = 10'b1101001010;
    exp_b2b = 22'b11_1110000110_1001111000;

    RST = 1'b0; wrn = 1'b1; rdn = 1'b1; rxd = 1'b1; data_in = 8'h00;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_reset_vals("init");
    @(posedge CLK); #1 RST = 1'b1;
    repeat (3) @(posedge CLK);

    // Single frame of A5 with exact bit timing
    wr(8'hA5);
    @(negedge CLK);
    @(negedge CLK);
    chk("a5_tbre_fall", tbre, 0);
    @(negedge CLK);
    chk("a5_tbre_rise", tbre, 1);
    chk("a5_tsre_busy", tsre, 0);
    chk("a5_start", txd, 0);
    for (int i = 0; i < 10; i++) begin
      cap_a5[i] = txd;
      repeat (CPB) @(negedge CLK);
    end
    chk("a5_bits", cap_a5, exp_a5);
    chk("a5_tsre_done", tsre, 1);
    repeat (5) @(posedge CLK);

    // Back-to-back frames; the third write lands while THR is full
    wr(8'h3C);
    repeat (3) @(negedge CLK);
    chk("b2b_start", txd, 0);
    fork
      begin
        for (int i = 0; i < 22; i++) begin
          cap_b2b[i] = txd;
          repeat (CPB) @(negedge CLK);
        end
      end
      begin
        repeat (6) @(posedge CLK);
        wr(8'hC3);
        repeat (4) @(posedge CLK);
        chk("b2b_thr_full", tbre, 0);
        wr(8'h99);
      end
    join
    chk("b2b_bits", cap_b2b, exp_b2b);
    repeat (50) @(negedge CLK);
    chk("b2b_idle_tsre", tsre, 1);
    chk("b2b_idle_tbre", tbre, 1);

    // Reset in the middle of a frame
    wr(8'h81);
    repeat (15) @(posedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);
    chk_reset_vals("midrst");
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    ones = 0;
    repeat (40) begin
      @(negedge CLK);
      if (txd === 1'b1) ones++;
    end
    chk("midrst_txd_idle", ones, 40);

    // Receive and read
    fe0 = fe_seen; ov0 = ov_seen;
    rx_frame(8'h5A, 1'b1);
    @(negedge CLK);
    chk("rx5a_ready", data_ready, 1);
    rd(8'h5A);

    // Bad stop bit
    rx_frame(8'h77, 1'b0);
    @(negedge CLK);
    chk("ferr_count", fe_seen - fe0, 1);
    chk("ferr_ready", data_ready, 0);

    // Overrun
    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    @(negedge CLK);
    chk("ovr_count", ov_seen - ov0, 1);
    chk("ovr_ready", data_ready, 1);
    rd(8'h22);

    // One-cycle glitch is ignored, receiver still works afterwards
    fe0 = fe_seen; ov0 = ov_seen;
    @(posedge CLK); #1 rxd = 1'b0;
    @(posedge CLK); #1 rxd = 1'b1;
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    chk("glitch_ready", data_ready, 0);
    chk("glitch_ferr", fe_seen - fe0, 0);
    rx_frame(8'hC9, 1'b1);
    @(negedge CLK);
    chk("post_glitch_ready", data_ready, 1);
    rd(8'hC9);
    chk("post_glitch_ovr", ov_seen - ov0, 0);

`ifdef UART_LOOPBACK_EN
    @(posedge CLK); #1 loopback = 1'b1;
    wr(8'hE7);
    repeat (60) @(posedge CLK);
    m_rbr = 8'hE7;
    @(negedge CLK);
    chk("lb_ready", data_ready, 1);
    rd(8'hE7);
    @(posedge CLK); #1 loopback = 1'b0;
`endif

    repeat (10) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
